// File: rtl/ofdm_pilot_insertion_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_tx_pkg
//  Description : Shared widths, field positions and LFSR taps for the OFDM
//                transmit blocks, plus the 14b -> 17b sample widening helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ofdm_tx_pkg;

  // Sample rail widths
  localparam int IQ14_W = 14;
  localparam int IQ17_W = 17;

  // Packed bus widths
  localparam int IN_W  = 32;
  localparam int OUT_W = 34;

  // 32-bit input format: I[31:18], Q[17:4], [3:0] unused
  localparam int IN_I_MSB = 31;
  localparam int IN_I_LSB = 18;
  localparam int IN_Q_MSB = 17;
  localparam int IN_Q_LSB = 4;

  // 34-bit output format: I[33:17], Q[16:0]
  localparam int OUT_I_MSB = 33;
  localparam int OUT_I_LSB = 17;
  localparam int OUT_Q_MSB = 16;
  localparam int OUT_Q_LSB = 0;

  // Pilot polarity LFSR, x^7 + x^4 + 1 (Fibonacci, shift left)
  localparam int LFSR_W      = 7;
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 3;

  // Left-justify a 14-bit rail into 17 bits; the scale-up by 8 cannot overflow
  function automatic logic [IQ17_W-1:0] widen_iq(input logic [IQ14_W-1:0] v);
    return {v, {(IQ17_W - IQ14_W){1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_pilot_insertion_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_pilot_lfsr
//  Description : 7-bit pilot polarity LFSR; steps once per advance pulse and
//                exposes bit 0 as the pilot sign (1 = negative pilot).
//  Revision    : 1.0  initial release
// ============================================================================
module ofdm_pilot_lfsr
  import ofdm_tx_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic polarity
);

  logic [LFSR_W-1:0] state;

  // Shift left, feeding back tap6 ^ tap3; reseeds on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[LFSR_W-2:0], state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO]};
    end
  end

  assign polarity = state[0];

endmodule
`default_nettype wire

// File: rtl/ofdm_pilot_insertion.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_pilot_insertion
//  Description : Merges a data subcarrier stream with BPSK pilots, widens
//                samples to 17-bit rails and frames NFFT-subcarrier symbols
//                with start/end-of-packet flags ahead of the IFFT.
//  Revision    : 1.0  initial release
// ============================================================================
module ofdm_pilot_insertion
  import ofdm_tx_pkg::*;
#(
  parameter int                NFFT          = 64,
  parameter int                PILOT_SPACING = 8,
  parameter int                PILOT_OFFSET  = 0,
  parameter int                PILOT_AMP     = 8192,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 7'h7F
) (
  input  logic             clock_clk,
  input  logic             reset_reset,
  input  logic [IN_W-1:0]  asi_in0_data,
  input  logic             asi_in0_valid,
  output logic             asi_in0_ready,
  output logic [OUT_W-1:0] aso_out0_data,
  output logic             aso_out0_valid,
  input  logic             aso_out0_ready,
  output logic             aso_out0_startofpacket,
  output logic             aso_out0_endofpacket
);

  localparam int IDX_W = $clog2(NFFT);

  // PILOT_SPACING divides a power-of-two NFFT, so the modulo is a bit mask
  localparam logic [IDX_W-1:0]  SP_MASK   = IDX_W'(PILOT_SPACING - 1);
  localparam logic [IDX_W-1:0]  P_OFF     = IDX_W'(PILOT_OFFSET);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NFFT - 1);
  localparam logic [IQ17_W-1:0] PILOT_POS = IQ17_W'(PILOT_AMP);
  localparam logic [IQ17_W-1:0] PILOT_NEG = IQ17_W'(-PILOT_AMP);

  logic [IDX_W-1:0] sc_idx;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             sop;
  logic             eop;

  logic             is_pilot;
  logic             at_first;
  logic             at_last;
  logic             load;
  logic             data_fire;
  logic             pilot_fire;
  logic             adv;
  logic             pilot_neg;
  logic [OUT_W-1:0] next_word;

  // The four padding bits of the input word carry no information
  logic unused_in_bits;
  assign unused_in_bits = &{1'b0, asi_in0_data[IN_Q_LSB-1:0]};

  assign is_pilot = (sc_idx & SP_MASK) == P_OFF;
  assign at_first = sc_idx == '0;
  assign at_last  = sc_idx == LAST_IDX;

  // The output register can take a new word when empty or being drained
  assign load = !out_valid || aso_out0_ready;

  // Data slots consume input; pilot slots never do
  assign asi_in0_ready = load && !is_pilot;
  assign data_fire     = asi_in0_ready && asi_in0_valid;

  // A pilot opening a symbol waits for data so symbols never start on idle input
  assign pilot_fire = load && is_pilot && (!at_first || asi_in0_valid);
  assign adv        = data_fire || pilot_fire;

  // Polarity steps once per symbol, when its last subcarrier is loaded
  ofdm_pilot_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clock_clk),
    .rst      (reset_reset),
    .advance  (adv && at_last),
    .polarity (pilot_neg)
  );

  // Build the word for the current subcarrier: signed pilot or widened sample
  always_comb begin
    next_word = '0;
    if (is_pilot) begin
      next_word[OUT_I_MSB:OUT_I_LSB] = pilot_neg ? PILOT_NEG : PILOT_POS;
    end else begin
      next_word[OUT_I_MSB:OUT_I_LSB] = widen_iq(asi_in0_data[IN_I_MSB:IN_I_LSB]);
      next_word[OUT_Q_MSB:OUT_Q_LSB] = widen_iq(asi_in0_data[IN_Q_MSB:IN_Q_LSB]);
    end
  end

  // Output register: reload on advance, empty when drained with nothing new
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sop       <= 1'b0;
      eop       <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_data  <= next_word;
      sop       <= at_first;
      eop       <= at_last;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

  // Subcarrier index advances with every loaded word and wraps at NFFT-1
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sc_idx <= '0;
    end else if (adv) begin
      sc_idx <= at_last ? '0 : sc_idx + IDX_W'(1);
    end
  end

  assign aso_out0_valid         = out_valid;
  assign aso_out0_data          = out_data;
  assign aso_out0_startofpacket = sop;
  assign aso_out0_endofpacket   = eop;

endmodule
`default_nettype wire
